// File: rtl/riscv_fetch.sv
// Instruction fetch stage: issues word reads to the icache (one outstanding),
// buffers responses in a 2-entry FIFO and hands them to decode.
module riscv_fetch #(
   parameter logic [31:0] BOOT_VECTOR = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST_N,
   output logic        fetch_valid_o,
   output logic [31:0] fetch_instr_o,
   output logic [31:0] fetch_pc_o,
   output logic        fetch_fault_o,
   input  logic        fetch_accept_i,
   input  logic        fetch_branch_i,
   input  logic [31:0] fetch_branch_pc_i,
   input  logic        fetch_invalidate_i,
   output logic        icache_rd_o,
   output logic [31:0] icache_pc_o,
   output logic        icache_flush_o,
   input  logic        icache_accept_i,
   input  logic        icache_valid_i,
   input  logic [31:0] icache_inst_i,
   input  logic        icache_error_i
);

   typedef enum logic {RUN, HALT} state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] req_pc_q;
   logic        outstanding_q;
   logic        drop_q;
   logic        flush_q;
   logic [1:0]  count_q;
   logic        rd_ptr_q;
   logic        wr_ptr_q;
   logic [31:0] instr_q [2];
   logic [31:0] fpc_q   [2];
   logic [1:0]  fault_q;

   logic        pop;
   logic        issue;
   logic        resp;
   logic        push;
   logic [2:0]  occ;
   logic [31:0] push_instr;
   logic        unused_bits;

   assign pop   = fetch_valid_o & fetch_accept_i;
   assign resp  = icache_valid_i & outstanding_q;
   assign push  = resp & !drop_q & !fetch_branch_i;
   assign issue = icache_rd_o & icache_accept_i;

   // Entries that will occupy the FIFO once the in-flight read lands.
   assign occ = {1'b0, count_q} + {2'b00, outstanding_q} - {2'b00, pop};

   assign icache_rd_o = (state_q == RUN) & !fetch_branch_i &
                        (!outstanding_q | resp) & (occ < 3'd2);
   assign icache_pc_o    = pc_q;
   assign icache_flush_o = flush_q;

   assign fetch_valid_o = (count_q != 2'd0);
   assign fetch_instr_o = instr_q[rd_ptr_q];
   assign fetch_pc_o    = fpc_q[rd_ptr_q];
   assign fetch_fault_o = fault_q[rd_ptr_q];

   // A faulting fetch never exposes the bus data to decode.
   assign push_instr  = icache_error_i ? 32'h0000_0000 : icache_inst_i;
   assign unused_bits = ^fetch_branch_pc_i[1:0];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q       <= RUN;
         pc_q          <= BOOT_VECTOR;
         req_pc_q      <= 32'h0000_0000;
         outstanding_q <= 1'b0;
         drop_q        <= 1'b0;
         flush_q       <= 1'b0;
         count_q       <= 2'd0;
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
         instr_q[0]    <= 32'h0000_0000;
         instr_q[1]    <= 32'h0000_0000;
         fpc_q[0]      <= 32'h0000_0000;
         fpc_q[1]      <= 32'h0000_0000;
         fault_q       <= 2'b00;
      end else begin
         flush_q <= fetch_invalidate_i;
         if (fetch_branch_i) begin
            // Redirect wins: empty the FIFO and mark any in-flight read stale.
            pc_q     <= {fetch_branch_pc_i[31:2], 2'b00};
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            state_q  <= RUN;
            if (resp) begin
               outstanding_q <= 1'b0;
               drop_q        <= 1'b0;
            end else if (outstanding_q) begin
               drop_q <= 1'b1;
            end
         end else begin
            if (issue) begin
               req_pc_q      <= pc_q;
               pc_q          <= pc_q + 32'd4;
               outstanding_q <= 1'b1;
            end else if (resp) begin
               outstanding_q <= 1'b0;
            end
            if (resp && drop_q)
               drop_q <= 1'b0;
            if (push) begin
               instr_q[wr_ptr_q] <= push_instr;
               fpc_q[wr_ptr_q]   <= req_pc_q;
               fault_q[wr_ptr_q] <= icache_error_i;
               wr_ptr_q          <= ~wr_ptr_q;
               if (icache_error_i)
                  state_q <= HALT;
            end
            if (pop)
               rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
         end
      end
   end

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: the bench plays both icache and decode,
// cycle by cycle, and checks outputs against hand-derived values.
module tb_riscv_fetch;

   logic        CLK;
   logic        RST_N;
   logic        fetch_valid_o;
   logic [31:0] fetch_instr_o;
   logic [31:0] fetch_pc_o;
   logic        fetch_fault_o;
   logic        fetch_accept_i;
   logic        fetch_branch_i;
   logic [31:0] fetch_branch_pc_i;
   logic        fetch_invalidate_i;
   logic        icache_rd_o;
   logic [31:0] icache_pc_o;
   logic        icache_flush_o;
   logic        icache_accept_i;
   logic        icache_valid_i;
   logic [31:0] icache_inst_i;
   logic        icache_error_i;

   int total = 0;
   int bad   = 0;

   riscv_fetch #(.BOOT_VECTOR(32'h0000_0000)) dut (
      .CLK               (CLK),
      .RST_N             (RST_N),
      .fetch_valid_o     (fetch_valid_o),
      .fetch_instr_o     (fetch_instr_o),
      .fetch_pc_o        (fetch_pc_o),
      .fetch_fault_o     (fetch_fault_o),
      .fetch_accept_i    (fetch_accept_i),
      .fetch_branch_i    (fetch_branch_i),
      .fetch_branch_pc_i (fetch_branch_pc_i),
      .fetch_invalidate_i(fetch_invalidate_i),
      .icache_rd_o       (icache_rd_o),
      .icache_pc_o       (icache_pc_o),
      .icache_flush_o    (icache_flush_o),
      .icache_accept_i   (icache_accept_i),
      .icache_valid_i    (icache_valid_i),
      .icache_inst_i     (icache_inst_i),
      .icache_error_i    (icache_error_i)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] imem(input logic [31:0] pc);
      case (pc)
         32'h00: return 32'h00510113;
         32'h04: return 32'h001101B3;
         32'h08: return 32'h00208233;
         32'h0C: return 32'h00418293;
         32'h14: return 32'h00628313;
         default: return 32'h00000013;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      fetch_accept_i     = 1'b0;
      fetch_branch_i     = 1'b0;
      fetch_branch_pc_i  = 32'h0;
      fetch_invalidate_i = 1'b0;
      icache_accept_i    = 1'b0;
      icache_valid_i     = 1'b0;
      icache_inst_i      = 32'h0;
      icache_error_i     = 1'b0;
   endtask

   task automatic nxt();
      @(negedge CLK);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST_N = 1'b0;
      clr_in();
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
   endtask

   initial begin
      RST_N = 1'b0;
      clr_in();
      repeat (2) @(negedge CLK);
      #1;
      chk("rst_valid", fetch_valid_o, 0);
      chk("rst_instr", fetch_instr_o, 0);
      chk("rst_pc", fetch_pc_o, 0);
      chk("rst_fault", fetch_fault_o, 0);
      chk("rst_flush", icache_flush_o, 0);
      chk("rst_icpc", icache_pc_o, 32'h0);

      // Streaming: cache answers next cycle, decode always accepts
      nxt; RST_N = 1'b1; icache_accept_i = 1; fetch_accept_i = 1; #1;
      chk("s1_rd0", icache_rd_o, 1);
      chk("s1_icpc0", icache_pc_o, 32'h0);
      nxt; icache_valid_i = 1; icache_inst_i = imem(32'h0); #1;
      chk("s1_icpc4", icache_pc_o, 32'h4);
      chk("s1_fv0", fetch_valid_o, 0);
      nxt; icache_inst_i = imem(32'h4); #1;
      chk("s1_icpc8", icache_pc_o, 32'h8);
      chk("s1_fv1", fetch_valid_o, 1);
      chk("s1_fpc0", fetch_pc_o, 32'h0);
      chk("s1_ins0", fetch_instr_o, 32'h00510113);
      nxt; icache_inst_i = imem(32'h8); #1;
      chk("s1_fpc4", fetch_pc_o, 32'h4);
      chk("s1_ins4", fetch_instr_o, 32'h001101B3);
      nxt; icache_inst_i = imem(32'hC); #1;
      chk("s1_fpc8", fetch_pc_o, 32'h8);
      chk("s1_ins8", fetch_instr_o, 32'h00208233);
      chk("s1_flt", fetch_fault_o, 0);

      // Backpressure: decode stalls until FIFO is full
      do_reset;
      icache_accept_i = 1; #1;
      chk("s2_rd0", icache_rd_o, 1);
      nxt; icache_valid_i = 1; icache_inst_i = imem(32'h0); #1;
      chk("s2_icpc4", icache_pc_o, 32'h4);
      nxt; icache_inst_i = imem(32'h4); #1;
      chk("s2_fpc0a", fetch_pc_o, 32'h0);
      chk("s2_rd_full", icache_rd_o, 0);
      nxt; icache_valid_i = 0; #1;
      chk("s2_rd_hold", icache_rd_o, 0);
      chk("s2_fv", fetch_valid_o, 1);
      chk("s2_fpc0b", fetch_pc_o, 32'h0);
      nxt; fetch_accept_i = 1; #1;
      chk("s2_rd_resume", icache_rd_o, 1);
      chk("s2_icpc8", icache_pc_o, 32'h8);
      nxt; icache_valid_i = 1; icache_inst_i = imem(32'h8); #1;
      chk("s2_fpc4", fetch_pc_o, 32'h4);
      nxt; icache_valid_i = 0; fetch_accept_i = 0; fetch_invalidate_i = 1; #1;
      chk("s2_fpc8", fetch_pc_o, 32'h8);
      chk("s2_rd_outst", icache_rd_o, 0);
      // Reset in the middle of an outstanding read
      nxt; fetch_invalidate_i = 0; #1;
      chk("s2_flush_pre", icache_flush_o, 1);
      chk("s2_fv_pre", fetch_valid_o, 1);
      RST_N = 0; #1;
      chk("s2_rst_fv", fetch_valid_o, 0);
      chk("s2_rst_ins", fetch_instr_o, 0);
      chk("s2_rst_fpc", fetch_pc_o, 0);
      chk("s2_rst_flt", fetch_fault_o, 0);
      chk("s2_rst_flush", icache_flush_o, 0);
      chk("s2_rst_icpc", icache_pc_o, 0);
      nxt; RST_N = 1; clr_in(); fetch_accept_i = 1;
      icache_valid_i = 1; icache_inst_i = 32'hBAD0BAD0; #1;
      chk("s2_late_fv0", fetch_valid_o, 0);
      nxt; icache_valid_i = 0; #1;
      chk("s2_late_fv1", fetch_valid_o, 0);
      chk("s2_late_rd", icache_rd_o, 1);

      // Redirect while a read is outstanding, then redirect on resp+pop
      do_reset;
      icache_accept_i = 1; fetch_accept_i = 1; #1;
      nxt; icache_valid_i = 1; icache_inst_i = imem(32'h0); #1;
      nxt; icache_inst_i = imem(32'h4); #1;
      nxt; icache_valid_i = 0; fetch_branch_i = 1; fetch_branch_pc_i = 32'h7; #1;
      chk("s3_rd_br", icache_rd_o, 0);
      nxt; fetch_branch_i = 0; icache_valid_i = 1; icache_inst_i = imem(32'h8); #1;
      chk("s3_fv_drop", fetch_valid_o, 0);
      chk("s3_rd_ret", icache_rd_o, 1);
      chk("s3_icpc4", icache_pc_o, 32'h4);
      nxt; icache_inst_i = imem(32'h4); #1;
      chk("s3_fv_empty", fetch_valid_o, 0);
      nxt; icache_inst_i = imem(32'h8); #1;
      chk("s3_fv", fetch_valid_o, 1);
      chk("s3_fpc4", fetch_pc_o, 32'h4);
      chk("s3_ins4", fetch_instr_o, 32'h001101B3);
      fetch_branch_i = 1; fetch_branch_pc_i = 32'h40; #1;
      chk("s4_rd_br", icache_rd_o, 0);
      nxt; fetch_branch_i = 0; icache_valid_i = 0; #1;
      chk("s4_fv", fetch_valid_o, 0);
      chk("s4_rd", icache_rd_o, 1);
      chk("s4_icpc", icache_pc_o, 32'h40);

      // Bus error at 0x10 halts fetch until a redirect
      do_reset;
      icache_accept_i = 1; fetch_accept_i = 1; #1;
      for (int k = 2; k <= 5; k++) begin
         nxt; icache_valid_i = 1; icache_inst_i = imem(32'(4 * (k - 2))); #1;
      end
      nxt; icache_inst_i = 32'hDEADBEEF; icache_error_i = 1; #1;
      chk("s5_fpcC", fetch_pc_o, 32'hC);
      chk("s5_icpc14", icache_pc_o, 32'h14);
      nxt; icache_valid_i = 0; icache_error_i = 0; #1;
      chk("s5_fv", fetch_valid_o, 1);
      chk("s5_fpc10", fetch_pc_o, 32'h10);
      chk("s5_flt", fetch_fault_o, 1);
      chk("s5_ins0", fetch_instr_o, 32'h0);
      chk("s5_rd_halt0", icache_rd_o, 0);
      nxt; icache_valid_i = 1; icache_inst_i = imem(32'h14); #1;
      chk("s5_rd_halt1", icache_rd_o, 0);
      nxt; icache_valid_i = 0; #1;
      chk("s5_fpc14", fetch_pc_o, 32'h14);
      chk("s5_flt14", fetch_fault_o, 0);
      chk("s5_rd_halt2", icache_rd_o, 0);
      nxt; fetch_branch_i = 1; fetch_branch_pc_i = 32'h100; #1;
      chk("s5_rd_br", icache_rd_o, 0);
      chk("s5_fv_empty", fetch_valid_o, 0);
      nxt; fetch_branch_i = 0; icache_accept_i = 0; #1;
      chk("s5_rd_run", icache_rd_o, 1);
      chk("s5_icpc100", icache_pc_o, 32'h100);

      // Invalidate pulses with a pending, unaccepted request
      nxt; fetch_invalidate_i = 1; #1;
      chk("s6_flush0", icache_flush_o, 0);
      nxt; #1;
      chk("s6_flush1", icache_flush_o, 1);
      nxt; fetch_invalidate_i = 0; #1;
      chk("s6_flush2", icache_flush_o, 1);
      nxt; #1;
      chk("s6_flush3", icache_flush_o, 0);
      chk("s6_rd", icache_rd_o, 1);
      chk("s6_icpc", icache_pc_o, 32'h100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/riscv_fetch.md
Name: riscv_fetch

Overview:
Instruction fetch stage, directly upstream of riscv_decode. Holds the architectural fetch PC and issues word reads to the instruction cache, with at most one read outstanding. Responses are buffered in a 2-entry FIFO and presented to decode over the fetch_valid/fetch_accept handshake. Decode branch redirects flush the stage, and decode invalidate requests are forwarded to the cache.

Parameters:
BOOT_VECTOR, 32'h00000000, PC of the first fetch after reset; bits [1:0] must be 0.

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
fetch_valid_o  output  1  FIFO head valid, to decode fetch_valid_i
fetch_instr_o  output  32  head instruction, to decode fetch_instr_i
fetch_pc_o  output  32  head PC, to decode fetch_pc_i
fetch_fault_o  output  1  head entry carries a fetch bus error
fetch_accept_i  input  1  decode consumes head, from decode fetch_accept_o
fetch_branch_i  input  1  redirect request, from decode fetch_branch_o
fetch_branch_pc_i  input  32  redirect target, from decode fetch_branch_pc_o
fetch_invalidate_i  input  1  cache invalidate request, from decode fetch_invalidate_o
icache_rd_o  output  1  read request
icache_pc_o  output  32  read address, word aligned
icache_flush_o  output  1  single-cycle cache invalidate pulse
icache_accept_i  input  1  cache accepts request this cycle
icache_valid_i  input  1  response valid, earliest one cycle after accept
icache_inst_i  input  32  response instruction
icache_error_i  input  1  response bus error, qualified by icache_valid_i

Behaviour:
- Reset (RST_N low, asynchronous):
  - pc_q = BOOT_VECTOR; FIFO count 0; outstanding_q = 0; drop_q = 0; state RUN.
  - icache_flush_o = 0. All FIFO storage = 0, so fetch_valid_o, fetch_instr_o, fetch_pc_o and fetch_fault_o are all 0.
  - Reset asserted mid-transaction abandons any outstanding read. A late icache_valid_i after reset release with outstanding_q = 0 is ignored.
- Definitions:
  - pop = fetch_valid_o & fetch_accept_i.
  - issue = icache_rd_o & icache_accept_i.
  - resp = icache_valid_i & outstanding_q.
- Request generation:
  - icache_rd_o = state==RUN & !fetch_branch_i & (!outstanding_q | resp) & (count_q + outstanding_q - pop) < 2.
  - icache_pc_o = pc_q.
  - icache_rd_o must stay asserted until icache_accept_i; icache_pc_o is stable while asserted.
- On issue:
  - req_pc_q <= pc_q; pc_q <= pc_q + 4, wrapping 32'hFFFFFFFC -> 0; outstanding_q <= 1.
- On resp (outstanding_q cleared unless issue in the same cycle):
  - If drop_q is set or fetch_branch_i is high, discard the response and clear drop_q.
  - Otherwise push {icache_inst_i, req_pc_q, icache_error_i} into the FIFO.
  - Error push: stored instruction forced to 32'h00000000, fault = 1, state -> HALT (no further requests).
- Throughput: one instruction per cycle when the cache responds in the cycle after accept and decode always accepts.
- FIFO:
  - 2 entries; fetch_valid_o = count_q != 0.
  - Head outputs are combinational from storage.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - A push is never attempted when full; the request gating guarantees this.
- Redirect (fetch_branch_i high for one cycle), takes priority over all other events that cycle:
  - pc_q <= {fetch_branch_pc_i[31:2], 2'b00}.
  - FIFO count <= 0, so fetch_valid_o is 0 next cycle; the pop is ignored.
  - state <= RUN.
  - If outstanding_q and no resp this cycle, drop_q <= 1.
  - First new request: next cycle if nothing is outstanding, otherwise the cycle the dropped response returns.
- Invalidate: icache_flush_o is fetch_invalidate_i registered (1 cycle latency, 1-cycle pulse per input cycle). PC and FIFO are unaffected.
- HALT: no requests issued. FIFO continues draining to decode. Exit only by redirect or reset.

Test Plan:
- Reset release, cache accepting immediately with 1-cycle response, decode always accepting -> icache_pc_o sequence 0x0, 0x4, 0x8. fetch_pc_o sequence 0x0, 0x4, 0x8 on consecutive cycles. Instructions 32'h00510113, 32'h001101B3 presented in order.
- Decode holds fetch_accept_i=0 -> after two responses, icache_rd_o drops and FIFO holds PCs 0x0, 0x4. Raise accept -> both drain, then fetching resumes at 0x8.
- Redirect to 32'h00000007 while a read to 0x8 is outstanding -> that response is dropped, fetch_valid_o=0, next icache_pc_o = 0x4, first delivered fetch_pc_o = 0x4.
- Redirect in the same cycle as a response and a pop -> response discarded, FIFO empty next cycle, pc_q = target.
- icache_error_i with response at PC 0x10 -> entry delivered with fetch_fault_o=1 and instr 0. No further icache_rd_o until a redirect to 0x100, then a request to 0x100 is issued.
- fetch_invalidate_i pulsed 2 cycles -> icache_flush_o high the 2 following cycles; pc_q unaffected. RST_N low mid-read -> all outputs 0 immediately.
